// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter sharing one Y86-64 ALU between two valid/ready requesters
module alu_rr_arbiter #(
  parameter int WIDTH = 64,
  parameter int FUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FUN_W-1:0] req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zf,
  output logic             rsp_sf,
  output logic             rsp_of,
  output logic             rsp_err
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic ptr, gnt1, gnt, id, of, err;
  logic [FUN_W-1:0] fun;
  logic [WIDTH-1:0] a, b, res;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    gnt1 = req1_valid && (!req0_valid || ptr);
    gnt = req0_valid || req1_valid;
    req0_ready = state == IDLE && req0_valid && !gnt1;
    req1_ready = state == IDLE && gnt1;
    rsp_valid = state == RESP;
    state_nx = state;
    if (state == IDLE && gnt) state_nx = EXEC;
    if (state == EXEC) state_nx = RESP;
    if (state == RESP && rsp_ready) state_nx = IDLE;
  end
  always_comb begin
    err = fun > FUN_W'(3);
    res = fun == FUN_W'(0) ? b + a :
          fun == FUN_W'(1) ? b - a :
          fun == FUN_W'(2) ? a & b :
          fun == FUN_W'(3) ? a ^ b : '0;
    of = fun == FUN_W'(0) ? (a[M] == b[M] && res[M] != a[M]) :
         fun == FUN_W'(1) ? (a[M] != b[M] && res[M] != b[M]) : 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= 1'b0;
      id <= 1'b0;
      fun <= '0;
      a <= '0;
      b <= '0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_zf <= 1'b0;
      rsp_sf <= 1'b0;
      rsp_of <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && gnt) begin
        id <= gnt1;
        fun <= gnt1 ? req1_fun : req0_fun;
        a <= gnt1 ? req1_a : req0_a;
        b <= gnt1 ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_id <= id;
        rsp_result <= res;
        rsp_zf <= !err && res == '0;
        rsp_sf <= res[M];
        rsp_of <= of;
        rsp_err <= err;
      end
      // served requester loses priority
      if (state == RESP && rsp_ready) ptr <= ~rsp_id;
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: table vectors, scoreboard and multi-cycle corner sequences for alu_rr_arbiter
module tb_alu_rr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [3:0] req0_fun = 0, req1_fun = 0;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zf, rsp_sf, rsp_of, rsp_err;
  logic [63:0] rsp_result;
  int checks = 0, failures = 0;
  typedef struct {
    logic id; logic [3:0] fun; logic [63:0] a, b, res; logic zf, sf, of, err;
  } vec_t;
  typedef struct {logic id; logic [63:0] res; logic zf, sf, of, err;} rsp_t;
  rsp_t sbq[$];
  rsp_t e;
  vec_t vecs[8];
  alu_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic rsp_t model(logic id, logic [3:0] f, logic [63:0] a, logic [63:0] b);
    rsp_t r;
    r.id = id;
    r.err = f > 3;
    case (f)
      0: r.res = b + a;
      1: r.res = b - a;
      2: r.res = a & b;
      3: r.res = a ^ b;
      default: r.res = 0;
    endcase
    r.of = f == 0 ? (a[63] == b[63] && r.res[63] != a[63]) :
           f == 1 ? (a[63] != b[63] && r.res[63] != b[63]) : 1'b0;
    r.zf = !r.err && r.res == 0;
    r.sf = r.res[63];
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && req0_valid && req0_ready) sbq.push_back(model(0, req0_fun, req0_a, req0_b));
    if (!rst && req1_valid && req1_ready) sbq.push_back(model(1, req1_fun, req1_a, req1_b));
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_rsp actual=%h required=none", rsp_result);
      end else begin
        e = sbq.pop_front();
        chk("sb_id", rsp_id, e.id);
        chk("sb_result", rsp_result, e.res);
        chk("sb_flags", {rsp_zf, rsp_sf, rsp_of, rsp_err}, {e.zf, e.sf, e.of, e.err});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(logic id, logic v, logic [3:0] f, logic [63:0] a, logic [63:0] b);
    if (id) begin req1_valid = v; req1_fun = f; req1_a = a; req1_b = b; end
    else begin req0_valid = v; req0_fun = f; req0_a = a; req0_b = b; end
  endtask
  task automatic run_vec(vec_t v, int i);
    int lat;
    set_req(v.id, 1, v.fun, v.a, v.b);
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), v.id ? req1_ready : req0_ready, 1);
    step();
    set_req(v.id, 0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 1;
    while (!rsp_valid && lat < 10) begin step(); lat++; end
    chk($sformatf("v%0d_latency", i), lat, 2);
    chk($sformatf("v%0d_id", i), rsp_id, v.id);
    chk($sformatf("v%0d_result", i), rsp_result, v.res);
    chk($sformatf("v%0d_zsoe", i), {rsp_zf, rsp_sf, rsp_of, rsp_err}, {v.zf, v.sf, v.of, v.err});
    step();
  endtask
  task automatic wait_rsp(string name);
    int n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
  endtask
  initial begin
    int t0, t1, cnt;
    logic [63:0] held;
    vecs[0] = '{0, 0, 64'd5, 64'd7, 64'd12, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 0, 1, 1, 0};
    vecs[2] = '{1, 1, 64'd1, 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 0, 0, 1, 0};
    vecs[3] = '{0, 3, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 64'd0, 1, 0, 0, 0};
    vecs[4] = '{1, 2, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000, 0, 1, 0, 0};
    vecs[5] = '{1, 7, 64'd3, 64'd4, 64'd0, 0, 0, 0, 1};
    vecs[6] = '{1, 1, 64'd5, 64'd5, 64'd0, 1, 0, 0, 0};
    vecs[7] = '{0, 1, 64'd5, 64'd3, 64'hFFFFFFFFFFFFFFFE, 0, 1, 0, 0};
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_outputs", {rsp_id, rsp_zf, rsp_sf, rsp_of, rsp_err, req0_ready, req1_ready}, 0);
    chk("rst_result", rsp_result, 0);
    step();
    rst = 0;
    foreach (vecs[i]) run_vec(vecs[i], i);
    // contention: grants must alternate starting from req0 after reset
    rst = 1; sbq.delete(); #1; rst = 0;
    set_req(0, 1, 0, 64'd1, 64'd2);
    set_req(1, 1, 1, 64'd1, 64'd10);
    rsp_ready = 1;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("cont");
      t1 = $time / 10;
      chk($sformatf("cont%0d_id", k), rsp_id, k % 2);
      if (k > 0) chk($sformatf("cont%0d_spacing", k), t1 - t0, 3);
      t0 = t1;
      @(negedge clk);
    end
    step();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (4) step();
    // backpressure with a competing requester
    rsp_ready = 0;
    set_req(0, 1, 0, 64'd100, 64'd23);
    @(negedge clk);
    step();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 3, 64'hF, 64'h1);
    wait_rsp("bp");
    held = rsp_result;
    chk("bp_result", held, 64'd123);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_result == held && rsp_id == 0 && !req0_ready && !req1_ready) cnt++;
    end
    chk("bp_held_cycles", cnt, 5);
    step();
    rsp_ready = 1;
    step();
    chk("bp_complete", rsp_valid, 0);
    chk("bp_next_grant", req1_ready, 1);
    step();
    set_req(1, 0, 0, 0, 0);
    wait_rsp("bp_next");
    chk("bp_next_result", rsp_result, 64'hE);
    step();
    step();
    // async reset during EXEC
    set_req(1, 1, 0, 64'd3, 64'd4);
    @(negedge clk);
    step();
    set_req(1, 0, 0, 0, 0);
    #1 rst = 1;
    sbq.delete();
    #1;
    chk("rexec_valid", rsp_valid, 0);
    chk("rexec_result", rsp_result, 0);
    step();
    rst = 0;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) cnt++; end
    chk("rexec_no_stale", cnt, 0);
    // async reset during RESP
    rsp_ready = 0;
    set_req(1, 1, 0, 64'd3, 64'd4);
    @(negedge clk);
    step();
    set_req(1, 0, 0, 0, 0);
    wait_rsp("rresp");
    chk("rresp_before", {rsp_id, rsp_result}, {1'b1, 64'd7});
    #1 rst = 1;
    sbq.delete();
    #1;
    chk("rresp_valid", rsp_valid, 0);
    chk("rresp_outputs", {rsp_id, rsp_zf, rsp_sf, rsp_of, rsp_err}, 0);
    chk("rresp_result", rsp_result, 0);
    step();
    rst = 0;
    rsp_ready = 1;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) cnt++; end
    chk("rresp_no_stale", cnt, 0);
    step();
    set_req(0, 1, 2, 64'hFF, 64'h0F);
    set_req(1, 1, 2, 64'hFF, 64'hF0);
    @(negedge clk);
    chk("post_rst_prio", {req0_ready, req1_ready}, 2'b10);
    step();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    wait_rsp("post_rst");
    chk("post_rst_result", rsp_result, 64'h0F);
    repeat (3) step();
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
